// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle MIPS main control unit:
//   - opcode constants (6-bit MIPS primary opcode field)
//   - ALU_op, ALUSrcB and PCSource encodings
//   - FSM state enumeration and the per-state control word
// Optional feature macro: MULTI_CYCLE_CTRL_JUMP_EN adds the S_JUMP state.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALUOP_RTYPE = 3'b000;
    localparam logic [2:0] ALUOP_ADD   = 3'b010;
    localparam logic [2:0] ALUOP_SUB   = 3'b110;
    localparam logic [2:0] ALUOP_SLT   = 3'b111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_FETCH_WAIT  = 4'd1,
        S_FETCH       = 4'd2,
        S_DECODE      = 4'd3,
        S_EXEC_R      = 4'd4,
        S_R_WB        = 4'd5,
        S_MEM_ADDR    = 4'd6,
        S_MEM_RD      = 4'd7,
        S_LW_WB       = 4'd8,
        S_MEM_WR_WAIT = 4'd9,
        S_MEM_WR      = 4'd10,
        S_BRANCH      = 4'd11,
        S_EXEC_I      = 4'd12,
        S_I_WB        = 4'd13,
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
        S_ILLEGAL     = 4'd14,
        S_JUMP        = 4'd15
`else
        S_ILLEGAL     = 4'd14
`endif
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_word_t;

    // Final state of an instruction: en_i is sampled here to pick FETCH or IDLE.
    function automatic logic is_terminal(input state_e s);
        case (s)
            S_R_WB, S_LW_WB, S_MEM_WR, S_BRANCH, S_I_WB, S_ILLEGAL: return 1'b1;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
            S_JUMP: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_out_rom.sv
// ---------------------------------------------------------------------------
// ctrl_out_rom
// Pure state -> control-word lookup for the multi-cycle control FSM.
// Ports:
//   state_i  current FSM state
//   slti_i   EXEC_I sub-state bit (1 = slti, 0 = addi)
//   cw_o     datapath control word for this state
// Optional feature macro: MULTI_CYCLE_CTRL_JUMP_EN (adds the JUMP word).
// ---------------------------------------------------------------------------
module ctrl_out_rom
    import ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic       slti_i,
    output ctrl_word_t cw_o
);

    always_comb begin
        cw_o = '0;
        case (state_i)
            S_FETCH_WAIT: begin
                // Read is presented but nothing is loaded until memory is ready.
                cw_o.mem_read  = 1'b1;
                cw_o.alu_src_b = SRCB_FOUR;
                cw_o.alu_op    = ALUOP_ADD;
                cw_o.pc_source = PCSRC_ALU;
            end
            S_FETCH: begin
                cw_o.mem_read  = 1'b1;
                cw_o.ir_write  = 1'b1;
                cw_o.pc_write  = 1'b1;
                cw_o.alu_src_b = SRCB_FOUR;
                cw_o.alu_op    = ALUOP_ADD;
                cw_o.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                cw_o.alu_src_b = SRCB_IMM_SH2;
                cw_o.alu_op    = ALUOP_ADD;
            end
            S_EXEC_R: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_RT;
                cw_o.alu_op    = ALUOP_RTYPE;
            end
            S_R_WB: begin
                cw_o.reg_dst    = 1'b1;
                cw_o.reg_write  = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_IMM;
                cw_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                cw_o.mem_read = 1'b1;
                cw_o.iord     = 1'b1;
            end
            S_LW_WB: begin
                cw_o.mem_to_reg = 1'b1;
                cw_o.reg_write  = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            S_MEM_WR_WAIT: begin
                cw_o.mem_write = 1'b1;
                cw_o.iord      = 1'b1;
            end
            S_MEM_WR: begin
                cw_o.mem_write  = 1'b1;
                cw_o.iord       = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                cw_o.alu_src_a     = 1'b1;
                cw_o.alu_src_b     = SRCB_RT;
                cw_o.alu_op        = ALUOP_SUB;
                cw_o.pc_write_cond = 1'b1;
                cw_o.pc_source     = PCSRC_ALUOUT;
                cw_o.instr_done    = 1'b1;
            end
            S_EXEC_I: begin
                cw_o.alu_src_a = 1'b1;
                cw_o.alu_src_b = SRCB_IMM;
                cw_o.alu_op    = slti_i ? ALUOP_SLT : ALUOP_ADD;
            end
            S_I_WB: begin
                cw_o.reg_write  = 1'b1;
                cw_o.instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                cw_o.illegal = 1'b1;
            end
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
            S_JUMP: begin
                cw_o.pc_write   = 1'b1;
                cw_o.pc_source  = PCSRC_JUMP;
                cw_o.instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
// Moore main control FSM for the multi-cycle MIPS datapath. Every output is a
// function of the state register only (state + decoded sub-state bits).
//
// Ports:
//   clk_i, rst_n_i       clock (rising edge), async active-low reset
//   en_i                 run enable, sampled in IDLE and terminal states
//   instr_op_i           opcode from IR, sampled in DECODE only
//   mem_ready_i          memory handshake
//   PCWrite_o .. ALU_op_o  datapath controls
//   instr_done_o         pulse in the last state of every instruction
//   illegal_o            pulse on an unsupported opcode
//   state_o              current state (debug)
//
// Optional feature macro: MULTI_CYCLE_CTRL_JUMP_EN (j instruction support).
//
// Memory handshake: to keep IRWrite/PCWrite and the sw instr_done Moore, the
// state entering FETCH or MEM_WR samples mem_ready_i one edge early. When it
// is low the FSM parks in FETCH_WAIT / MEM_WR_WAIT (strobe asserted, nothing
// loaded) and moves to FETCH / MEM_WR on the edge where it is seen high.
// MEM_RD has no per-cycle pulse, so it simply holds until mem_ready_i.
//
// state          | meaning
// ---------------+---------------------------------------------------------
// IDLE           | stopped, all outputs 0
// FETCH_WAIT     | instruction read pending, IR/PC not loaded
// FETCH          | instruction read completes, IR and PC+4 loaded
// DECODE         | branch target precompute, opcode dispatch
// EXEC_R         | R-type ALU operation
// R_WB           | R-type writeback to rd (terminal)
// MEM_ADDR       | lw/sw effective address
// MEM_RD         | data read, held until ready
// LW_WB          | load writeback from MDR to rt (terminal)
// MEM_WR_WAIT    | data write pending
// MEM_WR         | data write completes (terminal)
// BRANCH         | beq compare and conditional PC load (terminal)
// EXEC_I         | addi/slti ALU operation
// I_WB           | immediate writeback to rt (terminal)
// ILLEGAL        | unsupported opcode flagged (terminal)
// JUMP           | j target loaded into PC (terminal, optional)
// ---------------------------------------------------------------------------
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 3,
    parameter int ST_W     = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic [OP_W-1:0]     instr_op_i,
    input  logic                mem_ready_i,
    output logic                PCWrite_o,
    output logic                PCWriteCond_o,
    output logic                IorD_o,
    output logic                MemRead_o,
    output logic                MemWrite_o,
    output logic                IRWrite_o,
    output logic                MemtoReg_o,
    output logic                RegWrite_o,
    output logic                RegDst_o,
    output logic                ALUSrcA_o,
    output logic [1:0]          ALUSrcB_o,
    output logic [1:0]          PCSource_o,
    output logic [ALU_OP_W-1:0] ALU_op_o,
    output logic                instr_done_o,
    output logic                illegal_o,
    output logic [ST_W-1:0]     state_o
);

    state_e     state_q, state_d;
    logic       slti_q, slti_d;
    logic       store_q, store_d;
    state_e     fetch_next;
    ctrl_word_t cw;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            slti_q  <= 1'b0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slti_q  <= slti_d;
            store_q <= store_d;
        end
    end

    // Where IDLE and every terminal state go next.
    always_comb begin
        fetch_next = S_IDLE;
        if (en_i) begin
            fetch_next = mem_ready_i ? S_FETCH : S_FETCH_WAIT;
        end
    end

    always_comb begin
        state_d = state_q;
        slti_d  = slti_q;
        store_d = store_q;
        case (state_q)
            S_IDLE:       state_d = fetch_next;
            S_FETCH_WAIT: if (mem_ready_i) state_d = S_FETCH;
            S_FETCH:      state_d = S_DECODE;
            S_DECODE: begin
                slti_d  = 1'b0;
                store_d = 1'b0;
                if (instr_op_i == OP_W'(OP_RTYPE)) begin
                    state_d = S_EXEC_R;
                end else if (instr_op_i == OP_W'(OP_LW)) begin
                    state_d = S_MEM_ADDR;
                end else if (instr_op_i == OP_W'(OP_SW)) begin
                    state_d = S_MEM_ADDR;
                    store_d = 1'b1;
                end else if (instr_op_i == OP_W'(OP_BEQ)) begin
                    state_d = S_BRANCH;
                end else if (instr_op_i == OP_W'(OP_ADDI)) begin
                    state_d = S_EXEC_I;
                end else if (instr_op_i == OP_W'(OP_SLTI)) begin
                    state_d = S_EXEC_I;
                    slti_d  = 1'b1;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
                end else if (instr_op_i == OP_W'(OP_J)) begin
                    state_d = S_JUMP;
`endif
                end else begin
                    state_d = S_ILLEGAL;
                end
            end
            S_EXEC_R:   state_d = S_R_WB;
            S_MEM_ADDR: begin
                if (store_q) begin
                    state_d = mem_ready_i ? S_MEM_WR : S_MEM_WR_WAIT;
                end else begin
                    state_d = S_MEM_RD;
                end
            end
            S_MEM_RD:      if (mem_ready_i) state_d = S_LW_WB;
            S_MEM_WR_WAIT: if (mem_ready_i) state_d = S_MEM_WR;
            S_EXEC_I:      state_d = S_I_WB;
            default:       state_d = is_terminal(state_q) ? fetch_next : S_IDLE;
        endcase
    end

    ctrl_out_rom u_rom (
        .state_i (state_q),
        .slti_i  (slti_q),
        .cw_o    (cw)
    );

    assign PCWrite_o     = cw.pc_write;
    assign PCWriteCond_o = cw.pc_write_cond;
    assign IorD_o        = cw.iord;
    assign MemRead_o     = cw.mem_read;
    assign MemWrite_o    = cw.mem_write;
    assign IRWrite_o     = cw.ir_write;
    assign MemtoReg_o    = cw.mem_to_reg;
    assign RegWrite_o    = cw.reg_write;
    assign RegDst_o      = cw.reg_dst;
    assign ALUSrcA_o     = cw.alu_src_a;
    assign ALUSrcB_o     = cw.alu_src_b;
    assign PCSource_o    = cw.pc_source;
    assign ALU_op_o      = ALU_OP_W'(cw.alu_op);
    assign instr_done_o  = cw.instr_done;
    assign illegal_o     = cw.illegal;
    assign state_o       = ST_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_SLTI = 6'b001010;
    localparam logic [5:0] T_J    = 6'b000010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [5:0] op;
    logic       rdy;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALU_op;
    logic       instr_done, illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .en_i          (en),
        .instr_op_i    (op),
        .mem_ready_i   (rdy),
        .PCWrite_o     (PCWrite),
        .PCWriteCond_o (PCWriteCond),
        .IorD_o        (IorD),
        .MemRead_o     (MemRead),
        .MemWrite_o    (MemWrite),
        .IRWrite_o     (IRWrite),
        .MemtoReg_o    (MemtoReg),
        .RegWrite_o    (RegWrite),
        .RegDst_o      (RegDst),
        .ALUSrcA_o     (ALUSrcA),
        .ALUSrcB_o     (ALUSrcB),
        .PCSource_o    (PCSource),
        .ALU_op_o      (ALU_op),
        .instr_done_o  (instr_done),
        .illegal_o     (illegal),
        .state_o       (state)
    );

    // Control word: pcw pcwc iord mrd mwr irw m2r rw rdst srca srcb pcsrc alu done ill
    typedef logic [18:0] cw_t;
    cw_t act_w;
    assign act_w = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALU_op, instr_done, illegal};

    typedef enum {K_IDLE, K_FETCH_W, K_FETCH, K_DECODE, K_EXEC_R, K_R_WB, K_MADDR, K_MRD,
                  K_LW_WB, K_SW_W, K_SW, K_BR, K_EXEC_I, K_I_WB, K_ILL, K_JUMP} step_e;

    function automatic cw_t cw(input bit pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca,
                               input bit [1:0] srcb, pcsrc, input bit [2:0] alu,
                               input bit done, ill);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rdst, srca, srcb, pcsrc, alu, done, ill};
    endfunction

    // Expected controls for each step of an instruction, straight from the control table.
    function automatic cw_t word(input step_e s, input bit slti);
        case (s)
            K_FETCH_W: return cw(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 0,0);
            K_FETCH:   return cw(1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 3'b010, 0,0);
            K_DECODE:  return cw(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, 0,0);
            K_EXEC_R:  return cw(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b000, 0,0);
            K_R_WB:    return cw(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'b000, 1,0);
            K_MADDR:   return cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010, 0,0);
            K_MRD:     return cw(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0,0);
            K_LW_WB:   return cw(0,0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 3'b000, 1,0);
            K_SW_W:    return cw(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0,0);
            K_SW:      return cw(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 1,0);
            K_BR:      return cw(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110, 1,0);
            K_EXEC_I:  return cw(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, slti ? 3'b111 : 3'b010, 0,0);
            K_I_WB:    return cw(0,0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, 3'b000, 1,0);
            K_ILL:     return cw(0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 0,1);
            K_JUMP:    return cw(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b000, 1,0);
            default:   return '0;
        endcase
    endfunction

    // Per-cycle program: inputs to drive and the expected controls of that cycle.
    bit         en_q[$];
    bit         rdy_q[$];
    logic [5:0] op_q[$];
    cw_t        ex_q[$];
    cw_t        sb[$];

    int checks = 0;
    int errors = 0;
    int exp_done = 0, exp_ill = 0;
    int act_done = 0, act_ill = 0;
    int mon_idx = 0;

    task automatic add(input step_e s, input bit slti, input bit e, input logic [5:0] o);
        en_q.push_back(e);
        rdy_q.push_back(1'b1);
        op_q.push_back(o);
        ex_q.push_back(word(s, slti));
    endtask

    // A low ready in the previous cycle delays the access by one cycle.
    task automatic hold_prev();
        rdy_q[rdy_q.size()-1] = 1'b0;
    endtask

    function automatic bit rnd_bit();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom);
    endfunction

    task automatic instr(input logic [5:0] opc, input int wf, input int wm,
                         input bit en_end, input int idle_n);
        for (int i = 0; i < wf; i++) begin
            hold_prev();
            add(K_FETCH_W, 0, rnd_bit(), rnd_op());
        end
        add(K_FETCH, 0, rnd_bit(), rnd_op());
        add(K_DECODE, 0, rnd_bit(), opc);
        case (opc)
            T_R: begin
                add(K_EXEC_R, 0, rnd_bit(), rnd_op());
                add(K_R_WB, 0, en_end, rnd_op());
            end
            T_LW: begin
                add(K_MADDR, 0, rnd_bit(), rnd_op());
                for (int i = 0; i < wm; i++) begin
                    add(K_MRD, 0, rnd_bit(), rnd_op());
                    hold_prev();
                end
                add(K_MRD, 0, rnd_bit(), rnd_op());
                add(K_LW_WB, 0, en_end, rnd_op());
            end
            T_SW: begin
                add(K_MADDR, 0, rnd_bit(), rnd_op());
                for (int i = 0; i < wm; i++) begin
                    hold_prev();
                    add(K_SW_W, 0, rnd_bit(), rnd_op());
                end
                add(K_SW, 0, en_end, rnd_op());
            end
            T_BEQ: add(K_BR, 0, en_end, rnd_op());
            T_ADDI, T_SLTI: begin
                add(K_EXEC_I, opc == T_SLTI, rnd_bit(), rnd_op());
                add(K_I_WB, 0, en_end, rnd_op());
            end
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
            T_J: add(K_JUMP, 0, en_end, rnd_op());
`endif
            default: begin
                add(K_ILL, 0, en_end, rnd_op());
                exp_ill++;
            end
        endcase
        if (ex_q[ex_q.size()-1][1]) exp_done++;
        if (!en_end) begin
            for (int i = 0; i < idle_n; i++) add(K_IDLE, 0, i == idle_n - 1, rnd_op());
        end
    endtask

    // Monitor: pops one expected word per cycle while the program runs.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cw_t e;
            e = sb.pop_front();
            checks++;
            if (act_w !== e) begin
                errors++;
                $display("FAIL ctrl_word cycle %0d got %h exp %h", mon_idx, act_w, e);
            end
            if (instr_done === 1'b1) act_done++;
            if (illegal === 1'b1) act_ill++;
            mon_idx++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    logic [5:0] pick[9];

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        rdy   = 1'b0;
        op    = 6'h00;

        pick = '{T_R, T_LW, T_SW, T_BEQ, T_ADDI, T_SLTI, T_J, 6'h3f, 6'h15};

        add(K_IDLE, 0, 1'b1, 6'h00);
        instr(T_LW,   0, 0, 1, 0);
        instr(T_SW,   0, 2, 1, 0);
        instr(T_BEQ,  0, 0, 1, 0);
        instr(T_SLTI, 0, 0, 1, 0);
        instr(6'h3f,  0, 0, 1, 0);
        instr(T_J,    0, 0, 1, 0);
        instr(T_R,    0, 0, 0, 2);
        instr(T_ADDI, 2, 0, 1, 0);
        instr(T_LW,   1, 2, 1, 0);
        for (int n = 0; n < 80; n++) begin
            instr(pick[$urandom_range(0, 8)], $urandom_range(0, 2), $urandom_range(0, 3),
                  ($urandom % 4) != 0, $urandom_range(1, 3));
        end
        // End with a clean fetch request so the final reset lands in FETCH.
        en_q[en_q.size()-1]   = 1'b1;
        rdy_q[rdy_q.size()-1] = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 32'(act_w), 32'h0);
        chk("reset_state", 32'(state), 32'h0);
        rst_n = 1'b1;

        for (int c = 0; c < ex_q.size(); c++) begin
            @(posedge clk);
            #1;
            en  = en_q[c];
            rdy = rdy_q[c];
            op  = op_q[c];
            sb.push_back(ex_q[c]);
        end

        @(posedge clk);
        #1;
        chk("in_fetch_before_reset", 32'({MemRead, IRWrite, PCWrite}), 32'h7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midfetch_reset_ctrl", 32'(act_w), 32'h0);
        chk("midfetch_reset_state", 32'(state), 32'h0);
        @(negedge clk);
        en    = 1'b1;
        rdy   = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("fetch_after_release", 32'({MemRead, IRWrite, PCWrite}), 32'h7);

        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        chk("instr_done_count", 32'(act_done), 32'(exp_done));
        chk("illegal_count", 32'(act_ill), 32'(exp_ill));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
